// File: rtl/uart_rx_fifo_controller.sv
// UART receiver: 2-flop input synchroniser, mid-bit sampling frame FSM with optional parity,
// first-word-fall-through FIFO for good words, and sticky framing/parity/overrun flags.
module uart_rx_fifo_controller #(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 Clock_50,
    input  logic                 Resetn,
    input  logic                 Enable,
    input  logic                 Unload_data,
    input  logic                 Clear_errors,
    input  logic                 UART_RX_I,
    output logic [DATA_BITS-1:0] RX_data,
    output logic                 Empty,
    output logic                 Full,
    output logic                 Overrun,
    output logic                 Frame_error,
    output logic                 Parity_error
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic [FCNT_W-1:0] DEPTH_C   = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic                 rx_meta_q, rx_s_q;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 bit_done_s, stop_sample_s, parity_ok_s;
    logic                 push_s, frame_set_s, parity_set_s;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FCNT_W-1:0]    count_q, count_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 empty_q, empty_d, full_q, full_d;
    logic                 overrun_q, overrun_d, ferr_q, ferr_d, perr_q, perr_d;
    logic                 pop_s, wr_s, ovr_set_s;

    assign bit_done_s = (cnt_q == BIT_LAST);

    // Two-flop synchroniser on the asynchronous serial pin; idles high.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX_I;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Enable && !rx_s_q) state_d = S_START;
                else                   state_d = S_IDLE;
            end
            S_START: begin
                if (rx_s_q)                  state_d = S_IDLE;
                else if (cnt_q == HALF_LAST) state_d = S_DATA;
                else                         state_d = S_START;
            end
            S_DATA: begin
                if (bit_done_s && idx_q == IDX_LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                else                                 state_d = S_DATA;
            end
            S_PARITY: begin
                if (bit_done_s) state_d = S_STOP;
                else            state_d = S_PARITY;
            end
            S_STOP: begin
                if (bit_done_s) state_d = S_IDLE;
                else            state_d = S_STOP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame FSM outputs: bit timing, shift register, parity capture and stop-sample strobe.
    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        par_d         = par_q;
        stop_sample_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = 3'd0;
            end
            S_START: begin
                if (rx_s_q || cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_done_s) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_done_s) begin
                    cnt_d = '0;
                    par_d = rx_s_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_done_s) begin
                    cnt_d         = '0;
                    stop_sample_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Stop-bit classification: frame error takes precedence over a parity mismatch.
    always_comb begin
        if (PARITY_EN != 0) parity_ok_s = (calc_parity(shift_q, par_q) == 1'(PARITY_ODD));
        else                parity_ok_s = 1'b1;
        push_s       = stop_sample_s & rx_s_q & parity_ok_s;
        frame_set_s  = stop_sample_s & ~rx_s_q;
        parity_set_s = stop_sample_s & rx_s_q & ~parity_ok_s;
    end

    // Frame datapath registers.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    // FIFO control; when full a simultaneous pop frees the head slot that the push then reuses.
    always_comb begin
        pop_s     = Unload_data && (count_q != '0);
        wr_s      = push_s && ((count_q != DEPTH_C) || pop_s);
        ovr_set_s = push_s && (count_q == DEPTH_C) && !pop_s;
        wptr_d    = wr_s  ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d    = pop_s ? rptr_q + PTR_W'(1) : rptr_q;
        case ({wr_s, pop_s})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
        if (pop_s && count_q > FCNT_W'(1)) rx_data_d = mem_q[rptr_q + PTR_W'(1)];
        else if (wr_s && count_d == FCNT_W'(1) && (pop_s || count_q == '0)) rx_data_d = shift_q;
        else rx_data_d = rx_data_q;
        empty_d   = (count_d == '0);
        full_d    = (count_d == DEPTH_C);
        overrun_d = ovr_set_s    ? 1'b1 : (Clear_errors ? 1'b0 : overrun_q);
        ferr_d    = frame_set_s  ? 1'b1 : (Clear_errors ? 1'b0 : ferr_q);
        perr_d    = parity_set_s ? 1'b1 : (Clear_errors ? 1'b0 : perr_q);
    end

    // FIFO storage, pointers, head register and sticky flags.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rx_data_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            if (wr_s) mem_q[wptr_q] <= shift_q;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rx_data_q <= rx_data_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
        end
    end

    assign RX_data      = rx_data_q;
    assign Empty        = empty_q;
    assign Full         = full_q;
    assign Overrun      = overrun_q;
    assign Frame_error  = ferr_q;
    assign Parity_error = perr_q;

endmodule
